adt7311_poller: RTL and testbench
=================================

# adt7311_poller

Periodic SPI master for the on-board ADT7311 temperature sensor, sitting beside the TimingGenerator/BubbleInterface/SPILoader path as the producer that feeds temperature and over-temperature status to LEDDriver. After reset it issues the ADT7311 serial-interface reset sequence, then reads the 16-bit temperature register at a fixed poll interval. It publishes a signed 13-bit temperature, an update strobe and status flags. It never touches the W25Q32 bus.

## Interface
Parameters:
- POLLDIV, 12_000_000, MCLK cycles from nTEMPCS rising to next nTEMPCS falling (250 ms at 48 MHz, > 240 ms conversion time)
- OTLIMIT, 13'sd1280, over-temperature threshold in 0.0625 °C LSB (80 °C)

Ports:
- MCLK  in  1  48 MHz clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- nTEMPCS  out  1  sensor chip select, active low
- TEMPCLK  out  1  SPI clock, mode 3, idles high
- TEMPMOSI  out  1  sensor DIN
- TEMPMISO  in  1  sensor DOUT
- TEMP  out  13  last good temperature, two's complement, 0.0625 °C/LSB
- TEMPSTB  out  1  one-MCLK pulse when TEMP/flags update
- TEMPVALID  out  1  high after the first good read, held until reset
- OVERTEMP  out  1  TEMP >= OTLIMIT (signed compare) at last good read
- SENSORERR  out  1  last read returned 16'hFFFF or 16'h0000

## Operation
- Reset values: nTEMPCS=1, TEMPCLK=1, TEMPMOSI=1, TEMP=0, TEMPSTB=0, TEMPVALID=0, OVERTEMP=0, SENSORERR=0; state=SYNC.
- Bit engine: each bit is 12 MCLK cycles; TEMPCLK low for cycles 0-5, high for 6-11. TEMPMOSI is updated on the cycle TEMPCLK falls. TEMPMISO is captured on the cycle TEMPCLK rises, MSB first.
- States:
  - SYNC: nTEMPCS low, 12-cycle setup, then 32 bits of TEMPMOSI=1, then 12-cycle hold. Go to WAIT.
  - WAIT: nTEMPCS=1, TEMPCLK=1, TEMPMOSI=1. Count POLLDIV cycles, then go to CMD.
  - CMD: nTEMPCS low, 12-cycle setup, then shift 8'h50 (read, register 0x02). Go to DATA.
  - DATA: shift 16 bits in with TEMPMOSI=0, then 12-cycle hold. Go to UPDATE.
  - UPDATE: one cycle with nTEMPCS=1. Evaluate the captured word. Go to WAIT.
- Evaluation of captured word D[15:0]:
  - D is FFFF or 0000: SENSORERR=1; TEMP, TEMPVALID and OVERTEMP unchanged.
  - Otherwise: TEMP=D[15:3], SENSORERR=0, TEMPVALID=1, OVERTEMP=($signed(D[15:3]) >= OTLIMIT).
  - TEMPSTB pulses in UPDATE in both cases.
- The wait counter is wide enough for POLLDIV with no wrap. A counter that reaches POLLDIV-1 triggers the transition on the next edge.
- Reset asserted mid-transaction immediately forces the reset values, including nTEMPCS=1. After release the block restarts at SYNC. A partial frame never updates the outputs.

## Timing
- SYNC frame: 12 + 384 + 12 = 408 cycles with nTEMPCS low.
- Read frame: 12 + 288 + 12 = 312 cycles with nTEMPCS low. TEMPSTB follows the frame-ending nTEMPCS rise in the same cycle (UPDATE).
- First TEMPSTB: 408 + POLLDIV + 312 cycles (±1) after RST release. Then one TEMPSTB every POLLDIV + 313 cycles.
- TEMPCLK frequency during frames is 4 MHz. Minimum nTEMPCS high time is POLLDIV.
- All outputs are registered; no combinational path exists from TEMPMISO to any output.

## Test plan
- Reset, POLLDIV=100, model returns 16'h0C80 (25 °C):
  - SYNC shows exactly 32 TEMPCLK rises with MOSI=1.
  - MOSI carries 8'h50 on the next 8 rises.
  - First TEMPSTB arrives at cycle 820±1 with TEMP=13'h0190, TEMPVALID=1, OVERTEMP=0.
- Model returns 16'h2800 (80 °C) → TEMP=13'h0500, OVERTEMP=1. Next read 16'h27F8 → TEMP=13'h04FF, OVERTEMP=0.
- Model returns 16'hE480 (-55 °C) → TEMP=13'h1C90, OVERTEMP=0 (signed compare).
- After a good read of 0C80, MISO is stuck high (FFFF) → TEMPSTB pulses, SENSORERR=1, TEMP stays 13'h0190, TEMPVALID stays 1. The next good read clears SENSORERR.
- RST asserted at bit 10 of DATA → nTEMPCS=1 and TEMPCLK=1 in the same cycle, no TEMPSTB. After release, SYNC repeats in full.
- Check the period between consecutive TEMPSTB pulses = POLLDIV + 313 and the TEMPCLK high/low widths = 6 cycles each.

Source files
------------

// File: rtl/adt7311_poller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adt7311_poller: SPI mode-3 master that resyncs the ADT7311 and polls TEMP.  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module adt7311_poller #(
  parameter int unsigned       POLLDIV = 12_000_000,
  parameter logic signed [12:0] OTLIMIT = 13'sd1280
) (
  input  logic        MCLK,
  input  logic        RST,
  output logic        nTEMPCS,
  output logic        TEMPCLK,
  output logic        TEMPMOSI,
  input  logic        TEMPMISO,
  output logic [12:0] TEMP,
  output logic        TEMPSTB,
  output logic        TEMPVALID,
  output logic        OVERTEMP,
  output logic        SENSORERR
);

  localparam int          CW       = (POLLDIV > 1) ? $clog2(POLLDIV) : 1;
  localparam logic [3:0]  SUB_LAST = 4'd11;
  localparam logic [3:0]  SUB_PRE  = 4'd15;
  localparam logic [7:0]  CMD_RD   = 8'h50;

  typedef enum logic [2:0] {
    S_SYNC   = 3'd0,
    S_WAIT   = 3'd1,
    S_CMD    = 3'd2,
    S_DATA   = 3'd3,
    S_UPDATE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    slot_q, slot_d;
  logic [3:0]    sub_q, sub_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [15:0]   shift_q, shift_d;
  logic          ncs_q, ncs_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic [12:0]   temp_q, temp_d;
  logic          stb_q, stb_d;
  logic          valid_q, valid_d;
  logic          ot_q, ot_d;
  logic          err_q, err_d;

  logic [5:0]    last_slot;
  logic          in_frame;
  logic          is_bit;
  logic          bit_val;
  logic [2:0]    cmd_idx;

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      state_q <= S_SYNC;
      slot_q  <= 6'd0;
      sub_q   <= SUB_PRE;
      wcnt_q  <= '0;
      shift_q <= 16'h0000;
      ncs_q   <= 1'b1;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b1;
      temp_q  <= 13'h0000;
      stb_q   <= 1'b0;
      valid_q <= 1'b0;
      ot_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sub_q   <= sub_d;
      wcnt_q  <= wcnt_d;
      shift_q <= shift_d;
      ncs_q   <= ncs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      temp_q  <= temp_d;
      stb_q   <= stb_d;
      valid_q <= valid_d;
      ot_q    <= ot_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    sub_d     = sub_q;
    wcnt_d    = wcnt_q;
    shift_d   = shift_q;
    mosi_d    = mosi_q;
    temp_d    = temp_q;
    stb_d     = 1'b0;
    valid_d   = valid_q;
    ot_d      = ot_q;
    err_d     = err_q;
    last_slot = 6'd0;
    in_frame  = 1'b0;
    is_bit    = 1'b0;
    bit_val   = 1'b0;
    cmd_idx   = 3'd0;

    // Frames are 12-cycle slots: setup slot, bit slots, hold slot.
    case (state_q)
      S_SYNC:  last_slot = 6'd33;
      S_CMD:   last_slot = 6'd8;
      S_DATA:  last_slot = 6'd16;
      default: last_slot = 6'd0;
    endcase

    case (state_q)
      S_WAIT: begin
        if (wcnt_q == CW'(POLLDIV - 1)) begin
          state_d = S_CMD;
          wcnt_d  = '0;
          slot_d  = 6'd0;
          sub_d   = 4'd0;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_UPDATE: begin
        state_d = S_WAIT;
        wcnt_d  = '0;
      end
      default: begin
        // SUB_PRE marks the single idle cycle right after reset release.
        if (sub_q == SUB_PRE) begin
          sub_d = 4'd0;
        end else if (sub_q == SUB_LAST) begin
          sub_d = 4'd0;
          if (slot_q == last_slot) begin
            slot_d = 6'd0;
            wcnt_d = '0;
            case (state_q)
              S_SYNC:  state_d = S_WAIT;
              S_CMD:   state_d = S_DATA;
              default: state_d = S_UPDATE;
            endcase
          end else begin
            slot_d = slot_q + 6'd1;
          end
        end else begin
          sub_d = sub_q + 4'd1;
        end
      end
    endcase

    // Pin values are derived from the next state so they register alongside it.
    in_frame = ((state_d == S_SYNC) || (state_d == S_CMD) || (state_d == S_DATA))
               && (sub_d != SUB_PRE);
    is_bit   = ((state_d == S_SYNC) && (slot_d >= 6'd1) && (slot_d <= 6'd32)) ||
               ((state_d == S_CMD)  && (slot_d >= 6'd1) && (slot_d <= 6'd8))  ||
               ((state_d == S_DATA) && (slot_d <= 6'd15));
    cmd_idx  = 3'(4'd8 - slot_d[3:0]);

    case (state_d)
      S_SYNC:  bit_val = 1'b1;
      S_CMD:   bit_val = CMD_RD[cmd_idx];
      default: bit_val = 1'b0;
    endcase

    ncs_d  = ~in_frame;
    sclk_d = ~(is_bit && (sub_d < 4'd6));

    if (!in_frame) begin
      mosi_d = 1'b1;
    end else if (is_bit && (sub_d == 4'd0)) begin
      mosi_d = bit_val;
    end

    if ((state_d == S_DATA) && is_bit && (sub_d == 4'd6)) begin
      shift_d = {shift_q[14:0], TEMPMISO};
    end

    if (state_d == S_UPDATE) begin
      stb_d = 1'b1;
      if ((shift_q == 16'hFFFF) || (shift_q == 16'h0000)) begin
        err_d = 1'b1;
      end else begin
        temp_d  = shift_q[15:3];
        err_d   = 1'b0;
        valid_d = 1'b1;
        ot_d    = ($signed(shift_q[15:3]) >= OTLIMIT);
      end
    end
  end

  assign nTEMPCS   = ncs_q;
  assign TEMPCLK   = sclk_q;
  assign TEMPMOSI  = mosi_q;
  assign TEMP      = temp_q;
  assign TEMPSTB   = stb_q;
  assign TEMPVALID = valid_q;
  assign OVERTEMP  = ot_q;
  assign SENSORERR = err_q;

endmodule
`default_nettype wire

// File: tb/tb_adt7311_poller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_adt7311_poller: sensor model + scoreboard for adt7311_poller.            |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_adt7311_poller;

  localparam int unsigned POLLDIV = 100;
  localparam int          PERIOD  = POLLDIV + 313;
  localparam int          NSTB    = 16;

  logic        MCLK = 1'b0;
  logic        RST = 1'b1;
  logic        TEMPMISO = 1'b1;
  logic        nTEMPCS, TEMPCLK, TEMPMOSI, TEMPSTB, TEMPVALID, OVERTEMP, SENSORERR;
  logic [12:0] TEMP;

  adt7311_poller #(.POLLDIV(POLLDIV), .OTLIMIT(13'sd1280)) dut (
    .MCLK(MCLK), .RST(RST), .nTEMPCS(nTEMPCS), .TEMPCLK(TEMPCLK),
    .TEMPMOSI(TEMPMOSI), .TEMPMISO(TEMPMISO), .TEMP(TEMP), .TEMPSTB(TEMPSTB),
    .TEMPVALID(TEMPVALID), .OVERTEMP(OVERTEMP), .SENSORERR(SENSORERR)
  );

  always #5 MCLK = ~MCLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int stb_count = 0;

  always @(posedge MCLK) cyc++;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  typedef struct {
    logic [12:0] temp;
    logic        valid;
    logic        ot;
    logic        err;
  } exp_t;
  exp_t sbq[$];

  // Reference model of the published state, in plain arithmetic.
  logic [12:0] m_temp = 13'h0;
  logic        m_valid = 1'b0;
  logic        m_ot = 1'b0;

  logic [15:0] directed [9] = '{16'h0C80, 16'h2800, 16'h27F8, 16'hE480, 16'h0C80,
                                16'hFFFF, 16'h0C80, 16'h0000, 16'h0C80};
  int          word_idx = 0;

  function automatic logic [15:0] next_word();
    logic [15:0] w;
    int          r;
    logic [31:0] u;
    if (word_idx < 9) begin
      w = directed[word_idx];
    end else begin
      r = $urandom_range(0, 9);
      u = $urandom();
      w = (r == 0) ? 16'hFFFF : (r == 1) ? 16'h0000 : u[15:0];
    end
    word_idx++;
    return w;
  endfunction

  // ADT7311 bus model: one process owns all sensor-side state.
  logic        p_cs = 1'b1, p_sck = 1'b1;
  bit          in_frame = 0;
  bit          expect_sync = 1;
  int          rises = 0;
  logic [7:0]  cmd = 8'h00;
  bit          all1 = 1, data0 = 1;
  logic [15:0] cur_word = 16'h0;

  always @(nTEMPCS or TEMPCLK) begin
    if (TEMPCLK !== p_sck) begin
      if (TEMPCLK === 1'b1 && in_frame) begin
        rises++;
        if (rises <= 8) cmd = {cmd[6:0], TEMPMOSI};
        if (TEMPMOSI !== 1'b1) all1 = 0;
        if (rises > 8 && TEMPMOSI !== 1'b0) data0 = 0;
      end
      if (TEMPCLK === 1'b0 && in_frame && !expect_sync && rises >= 8 && rises < 24)
        TEMPMISO = cur_word[23 - rises];
      p_sck = TEMPCLK;
    end
    if (nTEMPCS !== p_cs) begin
      if (nTEMPCS === 1'b0 && !RST) begin
        in_frame = 1; rises = 0; cmd = 8'h00; all1 = 1; data0 = 1;
        if (!expect_sync) cur_word = next_word();
      end else if (nTEMPCS === 1'b1 && in_frame) begin
        in_frame = 0;
        if (RST) begin
          m_temp = 13'h0; m_valid = 0; m_ot = 0;
          sbq.delete();
          expect_sync = 1;
        end else if (expect_sync) begin
          expect_sync = 0;
          check("sync_rises", rises, 32);
          check("sync_mosi_ones", int'(all1), 1);
        end else begin
          int t;
          check("rd_rises", rises, 24);
          check("rd_cmd", int'(cmd), 8'h50);
          check("rd_mosi_zero", int'(data0), 1);
          if (cur_word == 16'hFFFF || cur_word == 16'h0000) begin
            sbq.push_back('{m_temp, m_valid, m_ot, 1'b1});
          end else begin
            t = (int'(cur_word) >= 32768) ? int'(cur_word) - 65536 : int'(cur_word);
            t = t >>> 3;
            m_temp  = t[12:0];
            m_valid = 1'b1;
            m_ot    = (t >= 1280);
            sbq.push_back('{m_temp, 1'b1, m_ot, 1'b0});
          end
        end
      end
      p_cs = nTEMPCS;
    end
  end

  // Monitor: pops one expectation per TEMPSTB and checks strobe spacing.
  int last_stb = 0;
  int seen_rel = -1;
  always @(negedge MCLK) begin
    if (TEMPSTB === 1'b1) begin
      exp_t e;
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL stb_unexpected: got strobe at cycle %0d, expected none", cyc);
      end else begin
        e = sbq.pop_front();
        check("temp", int'(TEMP), int'(e.temp));
        check("valid", int'(TEMPVALID), int'(e.valid));
        check("overtemp", int'(OVERTEMP), int'(e.ot));
        check("sensorerr", int'(SENSORERR), int'(e.err));
      end
      if (seen_rel != rel_cyc) begin
        seen_rel = rel_cyc;
        checks++;
        if (cyc - rel_cyc < 819 || cyc - rel_cyc > 821) begin
          errors++;
          $display("FAIL first_stb: got %0d cycles, expected 820+-1", cyc - rel_cyc);
        end
      end else begin
        check("stb_period", cyc - last_stb, PERIOD);
      end
      last_stb = cyc;
      stb_count++;
    end
  end

  // TEMPCLK half-period widths inside frames.
  logic p_w = 1'b1;
  int   run = 0;
  bit   hi_from_rise = 0;
  always @(negedge MCLK) begin
    if (nTEMPCS === 1'b0) begin
      if (TEMPCLK === p_w) begin
        run++;
      end else begin
        if (p_w === 1'b0) check("sck_low_width", run, 6);
        else if (hi_from_rise) check("sck_high_width", run, 6);
        hi_from_rise = (TEMPCLK === 1'b1);
        run = 1;
      end
    end else begin
      run = 0;
      hi_from_rise = 0;
    end
    p_w = TEMPCLK;
  end

  initial begin
    int budget;
    int base;
    repeat (3) @(posedge MCLK);
    @(negedge MCLK);
    check("rst_ncs", int'(nTEMPCS), 1);
    check("rst_sck", int'(TEMPCLK), 1);
    check("rst_mosi", int'(TEMPMOSI), 1);
    check("rst_temp", int'(TEMP), 0);
    check("rst_stb", int'(TEMPSTB), 0);
    check("rst_valid", int'(TEMPVALID), 0);
    check("rst_ot", int'(OVERTEMP), 0);
    check("rst_err", int'(SENSORERR), 0);
    RST = 1'b0;
    rel_cyc = cyc;

    budget = NSTB * PERIOD + 2000;
    while (stb_count < NSTB && budget > 0) begin
      @(negedge MCLK);
      budget--;
    end
    if (budget == 0) begin
      checks++; errors++;
      $display("FAIL stb_timeout: got %0d strobes, expected %0d", stb_count, NSTB);
    end

    budget = 2 * PERIOD + 1000;
    while (!(in_frame && !expect_sync && rises == 18) && budget > 0) begin
      @(negedge MCLK);
      budget--;
    end
    if (budget == 0) begin
      checks++; errors++;
      $display("FAIL data_bit10_timeout: got no DATA frame, expected one");
    end else begin
      @(negedge MCLK);
      RST = 1'b1;
      #1;
      check("abort_ncs", int'(nTEMPCS), 1);
      check("abort_sck", int'(TEMPCLK), 1);
      check("abort_stb", int'(TEMPSTB), 0);
      repeat (4) @(negedge MCLK);
      check("abort_valid", int'(TEMPVALID), 0);
      check("abort_temp", int'(TEMP), 0);
      RST = 1'b0;
      rel_cyc = cyc;
      base = stb_count;
      budget = 2 * PERIOD + 1500;
      while (stb_count < base + 2 && budget > 0) begin
        @(negedge MCLK);
        budget--;
      end
      if (budget == 0) begin
        checks++; errors++;
        $display("FAIL post_reset_timeout: got %0d strobes, expected %0d", stb_count - base, 2);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
